// File: rtl/pll_reset_ctrl.sv
// PLL power-up / lock-qualification / recovery sequencer on the reference clock.
// Holds the core in reset until lock is qualified and re-sequences the PLL on loss or request.
module pll_reset_ctrl #(
    parameter int PWR_HOLD      = 16,
    parameter int LOCK_STABLE   = 256,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int RELEASE_DELAY = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       req_reconfig,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic       lock_lost
);

    localparam int MAX_AB = (PWR_HOLD > LOCK_STABLE) ? PWR_HOLD : LOCK_STABLE;
    localparam int MAX_CD = (LOCK_TIMEOUT > RELEASE_DELAY) ? LOCK_TIMEOUT : RELEASE_DELAY;
    localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_T) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(PWR_HOLD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(RELEASE_DELAY - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_STABLE,
        S_DELAY,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       retry_n;
    logic             lost_n;
    logic             restart;
    logic             enter;
    logic             lock_p0;
    logic             lock_s;

    // pll_locked is asynchronous to refclk; only lock_s may feed decisions.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_p0 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_p0 <= pll_locked;
            lock_s  <= lock_p0;
        end
    end

    always_comb begin
        state_n = state;
        retry_n = retry_cnt;
        lost_n  = 1'b0;
        restart = 1'b0;
        if (req_reconfig && state != S_RUN) begin
            // Also covers HOLD, where it simply restarts the hold count.
            state_n = S_HOLD;
            retry_n = '0;
            restart = 1'b1;
        end else begin
            unique case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) state_n = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_n = S_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_n = retry_cnt + 4'd1;
                        state_n = (retry_n == RETRY_LIMIT) ? S_FAIL : S_HOLD;
                    end
                end
                S_STABLE: begin
                    if (!lock_s)                 state_n = S_WAIT_LOCK;
                    else if (cnt == STABLE_LAST) state_n = S_DELAY;
                end
                S_DELAY: begin
                    if (!lock_s) begin
                        state_n = S_HOLD;
                    end else if (cnt == DELAY_LAST) begin
                        state_n = S_RUN;
                        retry_n = '0;
                    end
                end
                S_RUN: begin
                    retry_n = '0;
                    // Loss of lock outranks a simultaneous reconfig request.
                    if (!lock_s) begin
                        state_n = S_HOLD;
                        lost_n  = 1'b1;
                    end else if (req_reconfig) begin
                        state_n = S_HOLD;
                    end
                end
                S_FAIL: begin
                    state_n = S_FAIL;
                end
                default: begin
                    state_n = S_HOLD;
                    retry_n = '0;
                end
            endcase
        end
        enter = restart || (state_n != state);
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state      <= S_HOLD;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            core_reset <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
            retry_cnt  <= 4'd0;
            lock_lost  <= 1'b0;
        end else begin
            state <= state_n;
            if (enter)
                cnt <= '0;
            else if (state != S_RUN && state != S_FAIL)
                cnt <= cnt + CNT_W'(1);
            pll_rst    <= (state_n == S_HOLD) || (state_n == S_FAIL);
            core_reset <= (state_n != S_RUN);
            ready      <= (state_n == S_RUN);
            fail       <= (state_n == S_FAIL);
            retry_cnt  <= retry_n;
            lock_lost  <= lost_n;
        end
    end

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Sequences the power-up, lock qualification and recovery of the core's clock PLL. The block runs on the PLL reference clock and drives the PLL reset. It qualifies the asynchronous lock flag and holds the core reset until the generated clocks are stable. It re-sequences the PLL on loss of lock or on an OSD reconfiguration request, and gives up after a bounded number of retries.

## Interface
- PWR_HOLD, 16: refclk cycles pll_rst is held high per attempt (≥1).
- LOCK_STABLE, 256: consecutive synchronized-locked cycles required to qualify lock (≥1).
- LOCK_TIMEOUT, 50000: cycles allowed in WAIT_LOCK before an attempt fails (≥2).
- RELEASE_DELAY, 1024: cycles between lock qualification and core_reset release (≥1).
- MAX_RETRY, 3: failed attempts tolerated before FAIL (1..15).
- refclk  in  1  PLL reference clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock flag, asynchronous to refclk.
- req_reconfig  in  1  synchronous request to restart the sequence; edge-insensitive, level sampled.
- pll_rst  out  1  PLL reset, active high.
- core_reset  out  1  core reset, active high.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retry_cnt  out  4  failed attempts in the current sequence.
- lock_lost  out  1  one-cycle pulse on loss of lock while in RUN.

## Operation
- pll_locked passes through a 2-flop synchronizer; lock_s is the second-stage output. All decisions use lock_s only.
- One shared cycle counter, width clog2(max of the four timing parameters)+1. It is cleared on every state entry.
- State HOLD: pll_rst=1, core_reset=1. After PWR_HOLD cycles the block goes to WAIT_LOCK.
- State WAIT_LOCK: pll_rst=0, core_reset=1.
  - lock_s=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0: retry_cnt increments. If the new value equals MAX_RETRY, go to FAIL; otherwise go to HOLD.
- State STABLE: pll_rst=0, core_reset=1.
  - lock_s=0: go back to WAIT_LOCK. The counter restarts, so the timeout restarts.
  - LOCK_STABLE consecutive cycles with lock_s=1: go to DELAY.
- State DELAY: pll_rst=0, core_reset=1.
  - lock_s=0: go to HOLD. retry_cnt is unchanged.
  - After RELEASE_DELAY cycles: go to RUN.
- State RUN: pll_rst=0, core_reset=0, ready=1, retry_cnt cleared to 0.
  - lock_s=0: lock_lost pulses for 1 cycle, then HOLD.
  - req_reconfig=1: go to HOLD with no lock_lost pulse.
  - If both happen in the same cycle, loss of lock wins and lock_lost pulses.
- State FAIL: pll_rst=1, core_reset=1, fail=1. retry_cnt holds MAX_RETRY. Only rst or req_reconfig leaves FAIL; req_reconfig clears retry_cnt and enters HOLD.
- req_reconfig in any state other than RUN or FAIL: go to HOLD with retry_cnt cleared. In HOLD this restarts the hold count.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.

## Timing
- Reset values (asynchronous): state HOLD, counter 0, synchronizer 0, pll_rst=1, core_reset=1, ready=0, fail=0, retry_cnt=0, lock_lost=0.
- After rst deasserts, pll_rst stays high for exactly PWR_HOLD rising edges and falls on the next one.
- Latency of lock synchronization: pll_locked stable high before edge k gives lock_s=1 after edge k+1, and STABLE is entered at edge k+2.
- Latency of core_reset release: core_reset falls exactly 2+LOCK_STABLE+RELEASE_DELAY edges after edge k, provided lock stays high.
- Latency of loss of lock: a drop of pll_locked before edge k gives pll_rst=1, core_reset=1 and lock_lost=1 at edge k+2.
- Any pll_locked glitch shorter than one cycle that is captured by the synchronizer is treated as a real loss.
- rst mid-operation returns every output to its reset value immediately, with no clock required.

## Test plan
Parameters for all scenarios: PWR_HOLD=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, RELEASE_DELAY=16, MAX_RETRY=3.
- Normal power-up: release rst, then raise pll_locked 10 cycles after pll_rst falls. Required: pll_rst high for exactly 4 cycles; core_reset falls 26 edges after locked is first sampled; ready=1; retry_cnt=0.
- Lock bounce: drop locked for 1 cycle at STABLE cycle 5. Required: return to WAIT_LOCK; qualification restarts; core_reset falls 26 edges after the second rise.
- Timeout and retry: hold locked=0. Required: three attempts, each with a 4-cycle pll_rst pulse and 32 WAIT_LOCK cycles; retry_cnt steps 1, 2, 3; fail=1 and pll_rst=1 stay latched. Then assert req_reconfig: retry_cnt=0 and the block is in HOLD.
- Loss in RUN: drop locked while ready=1. Required: 2 edges later lock_lost pulses for 1 cycle, core_reset=1 and pll_rst=1; with lock restored, the sequence repeats to RUN.
- Same-cycle events: assert req_reconfig in the same cycle lock_s falls in RUN. Required: lock_lost=1 and HOLD is entered. In a second run, req_reconfig alone gives HOLD with lock_lost=0.
- Mid-sequence reset: assert rst during DELAY for 1 ns, asynchronously. Required: all outputs return to reset values before the next edge, and the full sequence restarts.
